ws2812_rx: RTL and testbench

- Single-wire NZR receiver for the WS2812 LED protocol, running on the 50 MHz system clock.
- It is the receive end of the serial data line that the LED pattern transmitter drives.
- It recovers 24-bit GRB pixel words, streams them out with an index, and reports frame boundaries and protocol errors.
- Uses: on-board loopback checking of the transmitter, and capturing patterns from an external WS2812 source.

---
 rtl/ws2812_pkg.sv | 28 ++
 rtl/ws2812_rx_pulse_meter.sv | 58 +++++
 rtl/ws2812_rx.sv | 177 +++++++++++++++++
 tb/tb_ws2812_rx.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ws2812_pkg : shared WS2812 line timing, receiver state encoding, pixel type
// Revision   : 1.0
// ---------------------------------------------------------------------------
package ws2812_pkg;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_IDLE = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } state_t;

    // Nominal line timing in 50 MHz clock cycles
    localparam int T0H    = 20;
    localparam int T1H    = 40;
    localparam int TBIT   = 62;
    localparam int TRESET = 2500;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

endpackage
`default_nettype wire

// File: rtl/ws2812_rx_pulse_meter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pulse_meter : din synchroniser, edge detect and saturating run-length counter
// Revision    : 1.0
// ---------------------------------------------------------------------------
module pulse_meter #(
    parameter int RESET_CYC = 2500,
    parameter int CNT_W     = $clog2(RESET_CYC + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             din,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] width,
    output logic             low_timeout
);

    localparam logic [CNT_W-1:0] C_SAT = CNT_W'(RESET_CYC);

    logic             meta_q;
    logic             din_s_q;
    logic             din_dly_q;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] width_d;

    // width_q holds the length of the run up to the previous cycle, so on an
    // edge it is exactly the length of the level that just ended.
    always_comb begin
        rise = din_s_q & ~din_dly_q;
        fall = ~din_s_q & din_dly_q;
        if (rise || fall) begin
            width_d = CNT_W'(1);
        end else if (width_q == C_SAT) begin
            width_d = width_q;
        end else begin
            width_d = width_q + CNT_W'(1);
        end
        low_timeout = ~din_s_q & (width_d == C_SAT);
        width       = width_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q    <= 1'b0;
            din_s_q   <= 1'b0;
            din_dly_q <= 1'b0;
            width_q   <= '0;
        end else begin
            meta_q    <= din;
            din_s_q   <= meta_q;
            din_dly_q <= din_s_q;
            width_q   <= width_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ws2812_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ws2812_rx : WS2812 NZR receiver producing indexed GRB pixels and frame events
// Revision  : 1.0
// ---------------------------------------------------------------------------
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS   = 240,
    parameter int MIN_HIGH   = 8,
    parameter int BIT_THRESH = 30,
    parameter int MAX_HIGH   = 55,
    parameter int RESET_CYC  = 2500
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            din,
    output logic [23:0]                     pix_data,
    output logic                            pix_valid,
    output logic [$clog2(NUM_LEDS)-1:0]     pix_index,
    output logic                            frame_done,
    output logic [$clog2(NUM_LEDS+1)-1:0]   frame_len,
    output logic                            overflow,
    output logic                            err
);

    localparam int IDX_W = $clog2(NUM_LEDS);
    localparam int LEN_W = $clog2(NUM_LEDS + 1);
    localparam int CNT_W = $clog2(RESET_CYC + 1);

    localparam logic [CNT_W-1:0] C_MIN = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] C_THR = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_HIGH);
    localparam logic [LEN_W-1:0] C_NUM = LEN_W'(NUM_LEDS);

    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] width;
    logic             low_timeout;

    pulse_meter #(
        .RESET_CYC (RESET_CYC),
        .CNT_W     (CNT_W)
    ) u_meter (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         (din),
        .rise        (rise),
        .fall        (fall),
        .width       (width),
        .low_timeout (low_timeout)
    );

    state_t           state_q,      state_d;
    logic [4:0]       bit_cnt_q,    bit_cnt_d;
    logic [23:0]      shift_q,      shift_d;
    logic [LEN_W-1:0] pix_cnt_q,    pix_cnt_d;
    pixel_t           pix_data_q,   pix_data_d;
    logic             pix_valid_q,  pix_valid_d;
    logic [IDX_W-1:0] pix_index_q,  pix_index_d;
    logic             frame_done_q, frame_done_d;
    logic [LEN_W-1:0] frame_len_q,  frame_len_d;
    logic             overflow_q,   overflow_d;
    logic             err_q,        err_d;
    logic [23:0]      new_shift;
    logic             abort;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        pix_cnt_d    = pix_cnt_q;
        pix_data_d   = pix_data_q;
        pix_index_d  = pix_index_q;
        frame_len_d  = frame_len_q;
        overflow_d   = overflow_q;
        pix_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        abort        = 1'b0;
        new_shift    = {shift_q[22:0], (width > C_THR)};

        case (state_q)
            S_SYNC: begin
                if (low_timeout) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (rise) state_d = S_HIGH;
            end
            S_HIGH: begin
                if (fall) begin
                    if ((width < C_MIN) || (width > C_MAX)) begin
                        abort = 1'b1;
                    end else begin
                        shift_d = new_shift;
                        state_d = S_LOW;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = 5'd0;
                            if (pix_cnt_q < C_NUM) begin
                                pix_valid_d = 1'b1;
                                pix_data_d  = pixel_t'(new_shift);
                                pix_index_d = pix_cnt_q[IDX_W-1:0];
                                pix_cnt_d   = pix_cnt_q + LEN_W'(1);
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end else if (width == C_MAX) begin
                    // Still high with MAX_HIGH cycles already counted: over-long pulse
                    abort = 1'b1;
                end
            end
            S_LOW: begin
                if (rise) begin
                    state_d = S_HIGH;
                end else if (low_timeout) begin
                    frame_done_d = 1'b1;
                    frame_len_d  = pix_cnt_q;
                    err_d        = (bit_cnt_q != 5'd0);
                    overflow_d   = 1'b0;
                    pix_cnt_d    = '0;
                    bit_cnt_d    = 5'd0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_SYNC;
        endcase

        if (abort) begin
            err_d     = 1'b1;
            bit_cnt_d = 5'd0;
            pix_cnt_d = '0;
            state_d   = S_SYNC;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_SYNC;
            bit_cnt_q    <= 5'd0;
            shift_q      <= '0;
            pix_cnt_q    <= '0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_index_q  <= '0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
            overflow_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            pix_cnt_q    <= pix_cnt_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            pix_index_q  <= pix_index_d;
            frame_done_q <= frame_done_d;
            frame_len_q  <= frame_len_d;
            overflow_q   <= overflow_d;
            err_q        <= err_d;
        end
    end

    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign pix_index  = pix_index_q;
    assign frame_done = frame_done_q;
    assign frame_len  = frame_len_q;
    assign overflow   = overflow_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_ws2812_rx : directed bench with an event-queue model of the receiver
// Revision     : 1.0
// ---------------------------------------------------------------------------
module tb_ws2812_rx;
    import ws2812_pkg::*;

    localparam int N    = 4;
    localparam int MINH = 8;
    localparam int THR  = 30;
    localparam int MAXH = 55;
    localparam int RST  = 2500;

    localparam int K_PIX  = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        din     = 1'b0;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic [1:0]  pix_index;
    logic        frame_done;
    logic [2:0]  frame_len;
    logic        overflow;
    logic        err;

    ws2812_rx #(
        .NUM_LEDS   (N),
        .MIN_HIGH   (MINH),
        .BIT_THRESH (THR),
        .MAX_HIGH   (MAXH),
        .RESET_CYC  (RST)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_index  (pix_index),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .overflow   (overflow),
        .err        (err)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          kind;
        logic [23:0] data;
        int          idx;
        int          len;
        bit          perr;
    } ev_t;

    ev_t         exp_q[$];
    logic [23:0] got_pix[$];
    int          got_len      = -1;
    int          got_done_err = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- behavioural model: line events -> expected outputs
    bit m_sync;
    bit m_act;
    int m_low;
    int m_cnt;
    bit m_bits[$];

    function automatic void push_ev(int k, logic [23:0] d, int i, int l, bit p);
        ev_t e;
        e.kind = k; e.data = d; e.idx = i; e.len = l; e.perr = p;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        m_sync = 1'b0; m_act = 1'b0; m_low = 0; m_cnt = 0;
        m_bits.delete();
        exp_q.delete();
    endfunction

    function automatic void model_pulse(int h);
        logic [23:0] px;
        m_low = 0;
        if (!m_sync) return;
        m_act = 1'b1;
        if (h < MINH || h > MAXH) begin
            push_ev(K_ERR, 24'h0, 0, 0, 1'b0);
            m_sync = 1'b0; m_act = 1'b0; m_cnt = 0;
            m_bits.delete();
            return;
        end
        m_bits.push_back(h > THR);
        if (m_bits.size() == 24) begin
            px = 24'h0;
            foreach (m_bits[i]) px = {px[22:0], m_bits[i]};
            m_bits.delete();
            if (m_cnt < N) begin
                push_ev(K_PIX, px, m_cnt, 0, 1'b0);
                m_cnt++;
            end
        end
    endfunction

    function automatic void model_low(int n);
        m_low += n;
        if (m_low >= RST) begin
            if (!m_sync) begin
                m_sync = 1'b1;
            end else if (m_act) begin
                push_ev(K_DONE, 24'h0, 0, m_cnt, m_bits.size() != 0);
                m_act = 1'b0; m_cnt = 0;
                m_bits.delete();
            end
        end
    endfunction

    // ---------------- compare process
    always @(negedge clk) begin : cmp
        ev_t e;
        if (reset_n && (pix_valid || frame_done || err)) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: pv=%0b fd=%0b err=%0b, expected none (t=%0t)",
                         pix_valid, frame_done, err, $time);
            end else begin
                e = exp_q.pop_front();
                case (e.kind)
                    K_PIX: begin
                        chk("pix_valid", 32'(pix_valid), 32'd1);
                        chk("pix_data", 32'(pix_data), 32'(e.data));
                        chk("pix_index", 32'(pix_index), e.idx);
                        chk("pix_no_err", 32'(err), 32'd0);
                        got_pix.push_back(pix_data);
                    end
                    K_DONE: begin
                        chk("frame_done", 32'(frame_done), 32'd1);
                        chk("frame_len", 32'(frame_len), e.len);
                        chk("done_err", 32'(err), 32'(e.perr));
                        chk("done_ovf_clr", 32'(overflow), 32'd0);
                        chk("done_no_pv", 32'(pix_valid), 32'd0);
                        got_len      = int'(frame_len);
                        got_done_err = int'(err);
                    end
                    default: begin
                        chk("err", 32'(err), 32'd1);
                        chk("err_no_fd", 32'(frame_done), 32'd0);
                        chk("err_no_pv", 32'(pix_valid), 32'd0);
                    end
                endcase
            end
        end
    end

    // ---------------- stimulus
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input int h, input int per);
        model_pulse(h);
        model_low(per - h);
        din = 1'b1;
        wait_cyc(h);
        din = 1'b0;
        wait_cyc(per - h);
    endtask

    task automatic drive_px(input logic [23:0] d, input int h0, input int h1, input int nbits);
        for (int i = 23; i > 23 - nbits; i--) drive_bit(d[i] ? h1 : h0, TBIT);
    endtask

    task automatic drive_low(input int n);
        model_low(n);
        din = 1'b0;
        wait_cyc(n);
    endtask

    task automatic do_reset(input logic line);
        din     = line;
        reset_n = 1'b0;
        model_reset();
        wait_cyc(3);
        reset_n = 1'b1;
    endtask

    task automatic settle(input string name);
        wait_cyc(8);
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pin_px(input string name, input int k, input logic [23:0] v);
        chk(name, (k < got_pix.size()) ? 32'(got_pix[k]) : 32'hDEAD_BEEF, 32'(v));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pix_data"},   32'(pix_data),   32'd0);
        chk({tag, "_pix_valid"},  32'(pix_valid),  32'd0);
        chk({tag, "_pix_index"},  32'(pix_index),  32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_frame_len"},  32'(frame_len),  32'd0);
        chk({tag, "_overflow"},   32'(overflow),   32'd0);
        chk({tag, "_err"},        32'(err),        32'd0);
    endtask

    initial begin
        #1;
        do_reset(1'b0);
        check_zero("reset");
        drive_low(2600);

        // Three nominal pixels
        got_pix.delete();
        drive_px(24'h00FF00, T0H, T1H, 24);
        drive_px(24'hA5A5A5, T0H, T1H, 24);
        drive_px(24'h000001, T0H, T1H, 24);
        drive_low(2600);
        settle("frame1_drain");
        chk("frame1_len", 32'(got_len), 32'd3);
        chk("frame1_err", 32'(got_done_err), 32'd0);
        pin_px("frame1_px0", 0, 24'h00FF00);
        pin_px("frame1_px1", 1, 24'hA5A5A5);
        pin_px("frame1_px2", 2, 24'h000001);

        // Threshold 30/31 and legal extremes 8/55
        got_pix.delete();
        drive_px(24'h5A0F3C, 30, 31, 24);
        drive_px(24'hC3817E, 8, 55, 24);
        drive_low(2600);
        settle("thresh_drain");
        pin_px("thresh_px0", 0, 24'h5A0F3C);
        pin_px("extreme_px1", 1, 24'hC3817E);
        chk("thresh_len", 32'(got_len), 32'd2);

        // Too-short pulse: error, following pixel ignored until resync
        got_pix.delete();
        drive_bit(T1H, TBIT);
        drive_bit(7, TBIT);
        drive_px(24'hFFFFFF, T0H, T1H, 24);
        drive_low(2600);
        drive_px(24'h123456, T0H, T1H, 24);
        drive_low(2600);
        settle("short_drain");
        chk("short_len", 32'(got_len), 32'd1);
        pin_px("short_px0", 0, 24'h123456);

        // Too-long pulse: error raised while still high
        got_pix.delete();
        drive_bit(56, TBIT);
        drive_px(24'hFF0000, T0H, T1H, 8);
        drive_low(2600);
        drive_px(24'h0F0F0F, T0H, T1H, 24);
        drive_low(2600);
        settle("long_drain");
        pin_px("long_px0", 0, 24'h0F0F0F);

        // 30 bits: one pixel then a partial one discarded at frame end
        got_pix.delete();
        drive_px(24'hABCDEF, T0H, T1H, 24);
        drive_px(24'h3C3C3C, T0H, T1H, 6);
        drive_low(2600);
        settle("partial_drain");
        chk("partial_len", 32'(got_len), 32'd1);
        chk("partial_err", 32'(got_done_err), 32'd1);

        // Overflow: 6 pixels into a 4-pixel receiver
        got_pix.delete();
        for (int i = 0; i < 6; i++) drive_px({8'(i), 8'(i * 17), 8'hA0}, T0H, T1H, 24);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(got_pix.size()), 32'd4);
        drive_low(2600);
        settle("ovf_drain");
        chk("ovf_len", 32'(got_len), 32'd4);
        chk("ovf_clear", 32'(overflow), 32'd0);
        drive_px(24'h010101, T0H, T1H, 24);
        drive_px(24'h020202, T0H, T1H, 24);
        drive_low(2600);
        settle("post_ovf_drain");
        chk("post_ovf_len", 32'(got_len), 32'd2);

        // Line high at reset release
        got_pix.delete();
        do_reset(1'b1);
        wait_cyc(100);
        drive_low(1000);
        drive_px(24'h777777, T0H, T1H, 24);
        drive_low(2600);
        drive_px(24'h13579B, T0H, T1H, 24);
        drive_low(2600);
        settle("high_rst_drain");
        chk("high_rst_len", 32'(got_len), 32'd1);
        pin_px("high_rst_px0", 0, 24'h13579B);

        // Reset asserted mid-pixel clears outputs without a clock edge
        got_pix.delete();
        drive_px(24'hFFFFFF, T0H, T1H, 10);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_zero("midrst");
        wait_cyc(3);
        reset_n = 1'b1;
        drive_low(2600);
        settle("midrst_drain");
        chk("midrst_no_pix", 32'(got_pix.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
